// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/done handshake.
// Single-cycle ops (FWD/ADD/AND/OR) finish on the accept edge. MUL iterates
// shift-add over WIDTH cycles. SLL/SRA/ROR move one bit per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for i_start; operands latched on the accept edge
//   S_RUN    | one iteration per cycle, r_cnt counts down to terminal 1
//   S_FINISH | o_done high, o_result/o_zero valid; back to idle next edge
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  input  logic [2:0]       i_select,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_busy,
  output logic             o_done
);

  // Shift-count width is derived from WIDTH, so it is not overridable.
  localparam int LOG2W = $clog2(WIDTH);
  localparam int SHW   = LOG2W + 1;
  localparam logic [SHW-1:0] LP_WCNT = SHW'(WIDTH);
  localparam logic [SHW-1:0] LP_ONE  = SHW'(1);

  localparam logic [2:0] OP_FWD = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_big;
  logic [SHW-1:0]   w_n;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_a_step;
  logic [WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0] w_fin_val;
  logic             w_last;

  // A shift amount of WIDTH or more saturates to WIDTH iterations.
  assign w_big = |(i_data2 >> LOG2W);

  // Iteration count and immediate result for the op presented at accept.
  always_comb begin
    w_n      = '0;
    w_single = i_data1;
    case (i_select)
      OP_FWD:  w_single = i_data2;
      OP_ADD:  w_single = i_data1 + i_data2;
      OP_AND:  w_single = i_data1 & i_data2;
      OP_OR:   w_single = i_data1 | i_data2;
      OP_MUL:  w_n = LP_WCNT;
      OP_SLL,
      OP_SRA:  w_n = w_big ? LP_WCNT : {1'b0, i_data2[LOG2W-1:0]};
      OP_ROR:  w_n = {1'b0, i_data2[LOG2W-1:0]};
      default: w_n = '0;
    endcase
  end

  // One iteration of the latched operation.
  always_comb begin
    w_a_step   = r_a;
    w_acc_step = r_b[0] ? (r_acc + r_a) : r_acc;
    case (r_op)
      OP_MUL,
      OP_SLL:  w_a_step = r_a << 1;
      OP_SRA:  w_a_step = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
      OP_ROR:  w_a_step = {r_a[0], r_a[WIDTH-1:1]};
      default: w_a_step = r_a;
    endcase
    w_fin_val = (r_op == OP_MUL) ? w_acc_step : w_a_step;
    w_last    = (r_cnt == LP_ONE);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_FINISH);
    case (r_state)
      S_IDLE:   if (i_start) w_next_state = (w_n == '0) ? S_FINISH : S_RUN;
      S_RUN:    if (w_last)  w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result/zero update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op     <= OP_FWD;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op  <= i_select;
            r_a   <= i_data1;
            r_b   <= i_data2;
            r_acc <= '0;
            r_cnt <= w_n;
            if (w_n == '0) begin
              r_result <= w_single;
              r_zero   <= (w_single == '0);
            end
          end
        end
        S_RUN: begin
          r_a   <= w_a_step;
          r_b   <= r_b >> 1;
          r_acc <= w_acc_step;
          r_cnt <= r_cnt - LP_ONE;
          if (w_last) begin
            r_result <= w_fin_val;
            r_zero   <= (w_fin_val == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8;
  logic [7:0]  d1_8, d2_8;
  logic [2:0]  sel8;
  logic [7:0]  res8;
  logic        zero8, busy8, done8;

  logic        start16;
  logic [15:0] d1_16, d2_16;
  logic [2:0]  sel16;
  logic [15:0] res16;
  logic        zero16, busy16, done16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(start8),
    .i_data1(d1_8), .i_data2(d2_8), .i_select(sel8),
    .o_result(res8), .o_zero(zero8), .o_busy(busy8), .o_done(done8)
  );

  seq_alu #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_reset(rst), .i_start(start16),
    .i_data1(d1_16), .i_data2(d2_16), .i_select(sel16),
    .o_result(res16), .o_zero(zero16), .o_busy(busy16), .o_done(done16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one 8-bit op, measure latency and busy cycles, check result and return to idle.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res,
                        input logic exp_z);
    int lat;
    int busy_cyc;
    sel8 = sel; d1_8 = a; d2_8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    d1_8 = 8'($urandom); d2_8 = 8'($urandom); sel8 = 3'($urandom);
    lat = 1; busy_cyc = 0;
    while (done8 !== 1'b1 && lat < 64) begin
      if (busy8 === 1'b1) busy_cyc++;
      tick();
      lat++;
    end
    if (busy8 === 1'b1) busy_cyc++;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_cyc, exp_lat);
    check({tag, " result"}, res8, exp_res);
    check({tag, " zero"}, zero8, exp_z);
    tick();
    check({tag, " done drops"}, done8, 1'b0);
    check({tag, " idle"}, busy8, 1'b0);
    check({tag, " result holds"}, res8, exp_res);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input int exp_lat, input logic [15:0] exp_res, input logic exp_z);
    int lat;
    sel16 = 3'd4; d1_16 = a; d2_16 = b; start16 = 1'b1;
    tick();
    start16 = 1'b0; d1_16 = 16'($urandom); d2_16 = 16'($urandom);
    lat = 1;
    while (done16 !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, res16, exp_res);
    check({tag, " zero"}, zero16, exp_z);
    tick();
    check({tag, " idle"}, busy16, 1'b0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    d1_8 = '0; d2_8 = '0; sel8 = '0;
    d1_16 = '0; d2_16 = '0; sel16 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset result", res8, 8'h00);
    check("reset zero", zero8, 1'b1);
    check("reset busy", busy8, 1'b0);
    check("reset done", done8, 1'b0);
    check("reset16 zero", zero16, 1'b1);
    tick();

    run_op("mul 5*-1",   3'd4, 8'h05, 8'hFF, 9, 8'hFB, 1'b0);
    run_op("mul -3*-3",  3'd4, 8'hFD, 8'hFD, 9, 8'h09, 1'b0);
    run_op("add wrap",   3'd1, 8'h7F, 8'h01, 1, 8'h80, 1'b0);
    run_op("and zero",   3'd2, 8'hF0, 8'h0F, 1, 8'h00, 1'b1);
    run_op("or",         3'd3, 8'hA0, 8'h05, 1, 8'hA5, 1'b0);
    run_op("fwd",        3'd0, 8'h11, 8'h6C, 1, 8'h6C, 1'b0);
    run_op("sra 2",      3'd6, 8'h90, 8'h02, 3, 8'hE4, 1'b0);
    run_op("sra 255",    3'd6, 8'h80, 8'hFF, 9, 8'hFF, 1'b0);
    run_op("sll 200",    3'd5, 8'h5A, 8'd200, 9, 8'h00, 1'b1);
    run_op("sll 3",      3'd5, 8'h5A, 8'h03, 4, 8'hD0, 1'b0);
    run_op("ror 9",      3'd7, 8'h81, 8'h09, 2, 8'hC0, 1'b0);
    run_op("ror 8",      3'd7, 8'h81, 8'h08, 1, 8'h81, 1'b0);
    run_op("sll 0",      3'd5, 8'h5A, 8'h00, 1, 8'h5A, 1'b0);

    // START pulses during RUN and during FINISH must be ignored.
    sel8 = 3'd4; d1_8 = 8'h03; d2_8 = 8'h04; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    sel8 = 3'd1; d1_8 = 8'h01; d2_8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 4;
    while (done8 !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    check("ignore latency", lat, 9);
    check("ignore result", res8, 8'h0C);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("ignore no restart", busy8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("ignore no second done", done8, 1'b0);
      tick();
    end
    check("ignore result holds", res8, 8'h0C);

    // Reset in the middle of a MUL, with START also high on the reset edge.
    sel8 = 3'd4; d1_8 = 8'h07; d2_8 = 8'h09; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    check("pre-reset busy", busy8, 1'b1);
    rst = 1'b1; start8 = 1'b1; sel8 = 3'd0; d2_8 = 8'h44;
    tick();
    rst = 1'b0; start8 = 1'b0;
    check("midreset result", res8, 8'h00);
    check("midreset zero", zero8, 1'b1);
    check("midreset busy", busy8, 1'b0);
    check("midreset done", done8, 1'b0);
    tick();
    check("start with reset ignored", busy8, 1'b0);
    run_op("fwd after reset", 3'd0, 8'h00, 8'h33, 1, 8'h33, 1'b0);

    run16("mul16 zero", 16'h0100, 16'h0100, 17, 16'h0000, 1'b1);
    run16("mul16 1234*3", 16'h1234, 16'h0003, 17, 16'h369C, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
